load_store_unit: RTL and testbench

Data-memory front end between the RV32I execute stage and the byte-lane data RAM. Accepts one load or store per handshake, generates word address, byte enables and lane-shifted write data, then sign- or zero-extends returned load data. RAM read data is combinational and RAM writes are sampled on clk when clk_en is high. The unit therefore drives RAM strobes from registered state and completes each access in a fixed number of cycles.

---
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : RV32I data-memory front end (word address, byte lanes,
//                   lane-shifted store data, load sign/zero extension).
// Option macro   : LSU_MISALIGNED_SPLIT_EN (split word-crossing accesses)
// Revision       : 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_is_store,
  input  logic [2:0]          i_funct3,
  input  logic [31:0]         i_addr,
  input  logic [31:0]         i_wdata,
  output logic                o_done,
  output logic [31:0]         o_rdata,
  output logic                o_misaligned,
  output logic                o_illegal,
  output logic                o_read_req,
  output logic [ADDR_WIDTH:0] o_read_addr,
  input  logic [DATA_WIDTH:0] i_read_data,
  output logic                o_write_enable,
  output logic [3:0]          o_byte_enable,
  output logic [ADDR_WIDTH:0] o_write_addr,
  output logic [DATA_WIDTH:0] o_write_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACCESS2, S_DONE} state_t;
  typedef logic [ADDR_WIDTH:0] waddr_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic        split_q, split_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;

  logic        req_illegal, req_misaligned, req_split;
  logic [3:0]  mask;
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  waddr_t      index;

  function automatic logic [31:0] extend_load(input logic [63:0] pair,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    sh = 32'(pair >> {off, 3'b000});
    case (f3)
      3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
      3'b100:  extend_load = {24'b0, sh[7:0]};
      3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
      3'b101:  extend_load = {16'b0, sh[15:0]};
      default: extend_load = sh;
    endcase
  endfunction

  // Request classification, evaluated on the incoming fields at acceptance.
  always_comb begin
    if (i_is_store) req_illegal = (i_funct3 > 3'd2);
    else            req_illegal = (i_funct3 == 3'd3) || (i_funct3 > 3'd5);
`ifdef LSU_MISALIGNED_SPLIT_EN
    req_misaligned = 1'b0;
    req_split      = ((i_funct3[1:0] == 2'd1) && (i_addr[1:0] == 2'd3)) ||
                     ((i_funct3[1:0] == 2'd2) && (i_addr[1:0] != 2'd0));
`else
    req_misaligned = ((i_funct3[1:0] == 2'd1) && i_addr[0]) ||
                     ((i_funct3[1:0] == 2'd2) && (i_addr[1:0] != 2'd0));
    req_split      = 1'b0;
`endif
    if (req_illegal) begin
      req_misaligned = 1'b0;
      req_split      = 1'b0;
    end
  end

  always_comb begin
    case (funct3_q[1:0])
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    be_wide    = {4'b0000, mask} << addr_q[1:0];
    wdata_wide = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    index      = waddr_t'(addr_q[31:2]);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    split_d  = split_q;
    lo_d     = lo_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    ill_d    = ill_q;
    if (clk_en) begin
      case (state_q)
        S_IDLE: if (i_valid) begin
          addr_d   = i_addr;
          wdata_d  = i_wdata;
          funct3_d = i_funct3;
          store_d  = i_is_store;
          split_d  = req_split;
          mis_d    = req_misaligned;
          ill_d    = req_illegal;
          state_d  = (req_illegal || req_misaligned) ? S_DONE : S_ACCESS;
        end
        S_ACCESS: begin
          if (!store_q) begin
            if (split_q) lo_d = i_read_data[31:0];
            else         rdata_d = extend_load({32'b0, i_read_data[31:0]}, addr_q[1:0], funct3_q);
          end
          state_d = split_q ? S_ACCESS2 : S_DONE;
        end
        S_ACCESS2: begin
          if (!store_q) rdata_d = extend_load({i_read_data[31:0], lo_q}, addr_q[1:0], funct3_q);
          state_d = S_DONE;
        end
        default: begin
          mis_d   = 1'b0;
          ill_d   = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      split_q  <= 1'b0;
      lo_q     <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      split_q  <= split_d;
      lo_q     <= lo_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      ill_q    <= ill_d;
    end
  end

  // Strobes decode straight from state so they collapse as soon as rst falls.
  always_comb begin
    o_ready        = rst && (state_q == S_IDLE);
    o_done         = (state_q == S_DONE);
    o_rdata        = rdata_q;
    o_misaligned   = mis_q;
    o_illegal      = ill_q;
    o_read_req     = 1'b0;
    o_write_enable = 1'b0;
    o_byte_enable  = 4'b0000;
    o_read_addr    = '0;
    o_write_addr   = '0;
    o_write_data   = '0;
    if (state_q == S_ACCESS) begin
      o_read_req     = !store_q;
      o_write_enable = store_q;
      o_byte_enable  = be_wide[3:0];
      o_read_addr    = index;
      o_write_addr   = index;
      o_write_data   = wdata_wide[31:0];
    end else if (state_q == S_ACCESS2) begin
      o_read_req     = !store_q;
      o_write_enable = store_q;
      o_byte_enable  = be_wide[7:4];
      o_read_addr    = index + 1'b1;
      o_write_addr   = index + 1'b1;
      o_write_data   = wdata_wide[63:32];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit : randomized self-checking bench for load_store_unit,
// checked against a byte-addressed memory reference model.
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b0, clk_en = 1'b1;
  logic        i_valid = 1'b0, i_is_store = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic        o_ready, o_done, o_misaligned, o_illegal, o_read_req, o_write_enable;
  logic [31:0] o_rdata, o_read_addr, o_write_addr, o_write_data, i_read_data;
  logic [3:0]  o_byte_enable;

  logic [7:0]  ref_mem [64];
  logic [31:0] ram [16];
  int          n_tests = 0, n_fail = 0;

  logic [3:0]  s_be [2];
  logic [31:0] s_wd [2], s_wa [2], s_ra [2];
  int          s_lat, s_nrd, s_nwr;
  logic        s_mis, s_ill;
  logic [31:0] s_rdata;

  load_store_unit dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_is_store(i_is_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_done(o_done), .o_rdata(o_rdata), .o_misaligned(o_misaligned), .o_illegal(o_illegal),
    .o_read_req(o_read_req), .o_read_addr(o_read_addr), .i_read_data(i_read_data),
    .o_write_enable(o_write_enable), .o_byte_enable(o_byte_enable),
    .o_write_addr(o_write_addr), .o_write_data(o_write_data)
  );

  always #5 clk = ~clk;

  always_comb i_read_data = ram[o_read_addr[3:0]];

  always @(posedge clk)
    if (clk_en && o_write_enable)
      for (int b = 0; b < 4; b++)
        if (o_byte_enable[b]) ram[o_write_addr[3:0]][8*b +: 8] <= o_write_data[8*b +: 8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic f_illegal(input logic st, input logic [2:0] f3);
    return st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [5:0] a6);
    int n = 1 << f3[1:0];
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[(int'(a6) + i) % 64]) << (8 * i);
    if (n == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
    if (n == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    check("ready_before", o_ready, 1);
    i_valid = 1; i_is_store = st; i_funct3 = f3; i_addr = a; i_wdata = wd;
    @(posedge clk);
    #1;
    i_valid = 0; i_addr = $urandom; i_wdata = $urandom; i_funct3 = 3'($urandom);
    s_lat = 0; s_nrd = 0; s_nwr = 0;
    for (int j = 0; j < 2; j++) begin s_be[j] = 0; s_wd[j] = 0; s_wa[j] = 0; s_ra[j] = 0; end
    for (int k = 1; k <= 8 && s_lat == 0; k++) begin
      @(negedge clk);
      if (o_done) begin
        s_lat = k; s_mis = o_misaligned; s_ill = o_illegal; s_rdata = o_rdata;
      end else begin
        if (o_read_req) begin
          if (s_nrd < 2) s_ra[s_nrd] = o_read_addr;
          s_nrd++;
        end
        if (o_write_enable) begin
          if (s_nwr < 2) begin
            s_wa[s_nwr] = o_write_addr; s_be[s_nwr] = o_byte_enable; s_wd[s_nwr] = o_write_data;
          end
          s_nwr++;
        end
      end
    end
    @(negedge clk);
    check("ready_after", o_ready, 1);
    check("flags_clear", {o_done, o_misaligned, o_illegal}, 0);
  endtask

  task automatic op(input logic st, input logic [2:0] f3, input logic [5:0] a6, input logic [31:0] wd);
    logic ill, mis, spl;
    int n, acc;
    logic [31:0] a;
    a = {26'b0, a6};
    n = 1 << f3[1:0];
    ill = f_illegal(st, f3);
`ifdef LSU_MISALIGNED_SPLIT_EN
    mis = 0;
    spl = !ill && (int'(a6[1:0]) + n > 4);
`else
    mis = !ill && ((n == 2 && a6[0]) || (n == 4 && a6[1:0] != 0));
    spl = 0;
`endif
    acc = (ill || mis) ? 0 : (spl ? 2 : 1);
    run_op(st, f3, a, wd);
    check("latency", s_lat, (acc == 0) ? 1 : 1 + acc);
    check("illegal", s_ill, ill);
    check("misaligned", s_mis, mis);
    check("read_reqs", s_nrd, st ? 0 : acc);
    check("writes", s_nwr, st ? acc : 0);
    for (int j = 0; j < acc; j++) begin
      if (st) check("waddr", s_wa[j], (a >> 2) + j);
      else    check("raddr", s_ra[j], (a >> 2) + j);
    end
    if (acc > 0 && !st) check("load_data", s_rdata, model_load(f3, a6));
    if (acc > 0 && st)
      for (int i = 0; i < n; i++) ref_mem[(int'(a6) + i) % 64] = wd[8*i +: 8];
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", o_ready, 0);
    check("rst_ctrl", {o_done, o_misaligned, o_illegal, o_read_req, o_write_enable, o_byte_enable}, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_addr", {o_read_addr, o_write_addr}, 0);
    check("rst_wdata", o_write_data, 0);
    rst = 1;
    @(negedge clk);
    check("ready_after_rst", o_ready, 1);

    for (int w = 0; w < 16; w++) op(1, 3'b010, 6'(w * 4), $urandom);

    op(1, 3'b010, 6'h08, 32'hDEADBEEF);
    check("sw_be", s_be[0], 4'b1111); check("sw_waddr", s_wa[0], 2);
    check("sw_wdata", s_wd[0], 32'hDEADBEEF); check("sw_lat", s_lat, 2);
    op(1, 3'b000, 6'h0D, 32'h000000A5);
    check("sb_be", s_be[0], 4'b0010); check("sb_waddr", s_wa[0], 3);
    check("sb_wdata", s_wd[0], 32'h0000A500);
    op(1, 3'b001, 6'h0E, 32'h00001234);
    check("sh_be", s_be[0], 4'b1100); check("sh_wdata", s_wd[0], 32'h12340000);

    op(1, 3'b010, 6'h0C, 32'h80FF7F01);
    op(0, 3'b000, 6'h0E, 0); check("lb", s_rdata, 32'hFFFFFFFF);
    op(0, 3'b100, 6'h0E, 0); check("lbu", s_rdata, 32'h000000FF);
    op(0, 3'b001, 6'h0E, 0); check("lh", s_rdata, 32'hFFFF80FF);
    op(0, 3'b101, 6'h0E, 0); check("lhu", s_rdata, 32'h000080FF);
    op(0, 3'b010, 6'h0C, 0); check("lw", s_rdata, 32'h80FF7F01);

    op(1, 3'b010, 6'h04, 32'h44332211);
    op(1, 3'b010, 6'h08, 32'h88776655);
    op(0, 3'b010, 6'h05, 0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    check("split_ra0", s_ra[0], 1); check("split_ra1", s_ra[1], 2);
    check("split_data", s_rdata, 32'h55443322); check("split_lat", s_lat, 3);
`else
    check("mis_lat", s_lat, 1); check("mis_flag", s_mis, 1); check("mis_noread", s_nrd, 0);
`endif

    op(1, 3'b011, 6'h10, 32'h12345678);
    check("ill_flag", s_ill, 1); check("ill_nowrite", s_nwr, 0);

    // clk_en stall while the store strobe is up
    @(negedge clk);
    i_valid = 1; i_is_store = 1; i_funct3 = 3'b010; i_addr = 32'h10; i_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 i_valid = 0;
    @(negedge clk);
    check("stall_we", o_write_enable, 1);
    clk_en = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_we_held", o_write_enable, 1);
      check("stall_no_done", o_done, 0);
    end
    clk_en = 1;
    @(negedge clk);
    check("stall_done", o_done, 1);
    check("stall_we_off", o_write_enable, 0);
    for (int i = 0; i < 4; i++) ref_mem[16 + i] = 8'(32'hCAFEF00D >> (8 * i));
    @(negedge clk);
    check("stall_ready", o_ready, 1);
    op(0, 3'b010, 6'h10, 0);

    // reset in the middle of a store
    @(negedge clk);
    i_valid = 1; i_is_store = 1; i_funct3 = 3'b010; i_addr = 32'h14; i_wdata = 32'h0BADC0DE;
    @(posedge clk);
    #1 i_valid = 0;
    @(negedge clk);
    check("rstmid_we", o_write_enable, 1);
    #1 rst = 0;
    #1;
    check("rstmid_we_drop", o_write_enable, 0);
    check("rstmid_ready", o_ready, 0);
    @(negedge clk);
    rst = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rstmid_no_done", o_done, 0);
      check("rstmid_ready_after", o_ready, 1);
    end
    op(0, 3'b010, 6'h14, 0);

    repeat (200) op(1'($urandom), 3'($urandom), 6'($urandom), $urandom);

    for (int w = 0; w < 16; w++)
      check("ram_final", ram[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
